// File: rtl/ex_unit_pkg.sv
// Shared constants for the execute stage: aluop/alusel codes, bus widths,
// FSM state encodings. SERIAL_SHIFT_EN selects the iterative shifter.
package ex_unit_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_DEF_W = 5;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_AND_OP = 8'h24;
    localparam logic [7:0] EXE_OR_OP  = 8'h25;
    localparam logic [7:0] EXE_XOR_OP = 8'h26;
    localparam logic [7:0] EXE_NOR_OP = 8'h27;
    localparam logic [7:0] EXE_SLL_OP = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP = 8'h02;
    localparam logic [7:0] EXE_SRA_OP = 8'h03;

    localparam logic [2:0] EXE_RES_NOP   = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT = 3'd2;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic is_shift_op(input logic [7:0] op);
        return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
    endfunction

endpackage

// File: rtl/ex_shifter.sv
// Shift unit for the execute stage. Barrel (combinational) by default;
// with SERIAL_SHIFT_EN it shifts one bit per cycle and holds acc/cnt.
module ex_shifter
    import ex_unit_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int SHAMT_W = SHAMT_DEF_W
)
`ifdef SERIAL_SHIFT_EN
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] value,
    input  logic [SHAMT_W-1:0] shamt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic [0:0]         state;
    logic [DATA_W-1:0]  acc;
    logic [SHAMT_W-1:0] cnt;
    logic [7:0]         op_q;

    assign busy   = (state == ST_SHIFT);
    assign done   = (state == ST_SHIFT) && (cnt == '0);
    assign result = acc;

    // Load on start, then walk acc one bit per cycle until cnt reaches zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= EXE_NOP_OP;
        end else if (state == ST_IDLE) begin
            if (start) begin
                acc   <= value;
                cnt   <= shamt;
                op_q  <= op;
                state <= ST_SHIFT;
            end
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (cnt != '0) begin
            cnt <= cnt - SHAMT_W'(1);
            if (op_q == EXE_SLL_OP)
                acc <= {acc[DATA_W-2:0], 1'b0};
            else if (op_q == EXE_SRA_OP)
                acc <= {acc[DATA_W-1], acc[DATA_W-1:1]};
            else
                acc <= {1'b0, acc[DATA_W-1:1]};
        end else begin
            state <= ST_IDLE;
        end
    end

`else
(
    input  logic [7:0]         op,
    input  logic [DATA_W-1:0]  value,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
);

    // Single-cycle barrel shift; SRA replicates the sign of value
    always_comb begin
        result = '0;
        case (op)
            EXE_SLL_OP: result = value << shamt;
            EXE_SRL_OP: result = value >> shamt;
            EXE_SRA_OP: result = $signed(value) >>> shamt;
            default:    result = '0;
        endcase
    end

`endif

endmodule

// File: rtl/ex_unit.sv
// Execute stage: logic ALU, shifts, result register toward mem/forwarding.
// SERIAL_SHIFT_EN swaps the barrel shifter for a one-bit-per-cycle shifter.
module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int SHAMT_W = SHAMT_DEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              ex_ready_o,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    output logic              res_valid_o,
    output logic              wreg_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              accept;
    logic              imm_res;
    logic              op_ok;
    logic              is_shift;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] sh_res;

    assign accept = id_valid_i & ex_ready_o & ~flush_i;

`ifdef SERIAL_SHIFT_EN
    logic              start;
    logic              sh_busy;
    logic              sh_done;
    logic [ADDR_W-1:0] wd_q;
    logic              wreg_q;

    assign start      = accept & is_shift;
    assign imm_res    = accept & ~is_shift;
    assign ex_ready_o = ~sh_busy;

    ex_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_i),
        .start  (start),
        .op     (aluop_i),
        .value  (reg2_i),
        .shamt  (reg1_i[SHAMT_W-1:0]),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_res)
    );

    // Hold the destination of a shift while it iterates
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= '0;
            wreg_q <= WRITE_DISABLE;
        end else if (start) begin
            wd_q   <= wd_i;
            wreg_q <= wreg_i;
        end
    end
`else
    assign imm_res    = accept;
    assign ex_ready_o = 1'b1;

    ex_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .op     (aluop_i),
        .value  (reg2_i),
        .shamt  (reg1_i[SHAMT_W-1:0]),
        .result (sh_res)
    );
`endif

    // Decode the aluop/alusel pair; unknown pairs leave op_ok low
    always_comb begin
        op_ok    = 1'b0;
        is_shift = 1'b0;
        alu_res  = '0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                op_ok = 1'b1;
                case (aluop_i)
                    EXE_AND_OP: alu_res = reg1_i & reg2_i;
                    EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                    EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                    EXE_NOR_OP: alu_res = ~(reg1_i | reg2_i);
                    default:    op_ok   = 1'b0;
                endcase
            end
            EXE_RES_SHIFT: begin
                if (is_shift_op(aluop_i)) begin
                    op_ok    = 1'b1;
                    is_shift = 1'b1;
                    alu_res  = sh_res;
                end
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    // Result register: rst beats flush beats a new result
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_o <= 1'b0;
            wreg_o      <= WRITE_DISABLE;
            wd_o        <= '0;
            wdata_o     <= '0;
        end else if (flush_i) begin
            res_valid_o <= 1'b0;
            wreg_o      <= WRITE_DISABLE;
        end else begin
            res_valid_o <= 1'b0;
            wreg_o      <= WRITE_DISABLE;
`ifdef SERIAL_SHIFT_EN
            if (sh_done) begin
                res_valid_o <= 1'b1;
                wreg_o      <= wreg_q;
                wd_o        <= wd_q;
                wdata_o     <= sh_res;
            end
`endif
            if (imm_res) begin
                res_valid_o <= 1'b1;
                wreg_o      <= wreg_i & op_ok;
                wd_o        <= wd_i;
                wdata_o     <= op_ok ? alu_res : '0;
            end
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed cases pinned by literals, then random
// traffic checked every cycle against a cycle-count reference model.
module tb_ex_unit;

    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL = 8'h7C;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_NOP = 8'h00;

`ifdef SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        id_valid_i;
    logic        ex_ready_o;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        res_valid_o;
    logic        wreg_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    always #5 clk = ~clk;

    ex_unit dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .id_valid_i  (id_valid_i),
        .ex_ready_o  (ex_ready_o),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .res_valid_o (res_valid_o),
        .wreg_o      (wreg_o),
        .wd_o        (wd_o),
        .wdata_o     (wdata_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_left = 0;
    logic [31:0] p_data;
    logic [4:0]  p_wd;
    logic        p_wreg;
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_wreg = 1'b0;
    logic [4:0]  exp_wd = '0;
    logic [31:0] exp_wdata = '0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  wd;
        logic        wreg;
    } res_t;
    res_t got_q[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Result of one operation straight from the instruction definitions
    task automatic ref_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic ok, output logic sh,
                          output logic [31:0] r);
        ok = 1'b1;
        sh = 1'b0;
        r  = '0;
        if (sel == 3'd1) begin
            case (op)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_NOR:  r = ~(a | b);
                default: ok = 1'b0;
            endcase
        end else if (sel == 3'd2) begin
            sh = 1'b1;
            case (op)
                OP_SLL:  r = b << a[4:0];
                OP_SRL:  r = b >> a[4:0];
                OP_SRA:  r = $signed(b) >>> a[4:0];
                default: begin ok = 1'b0; sh = 1'b0; end
            endcase
        end else begin
            ok = 1'b0;
        end
    endtask

    // Advance the model across the coming clock edge using current inputs
    task automatic model_step();
        logic ok, sh;
        logic [31:0] r;
        if (rst) begin
            m_left = 0;
            exp_valid = 0; exp_wreg = 0; exp_wd = '0; exp_wdata = '0;
        end else if (flush_i) begin
            m_left = 0;
            exp_valid = 0; exp_wreg = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                exp_valid = 1; exp_wreg = p_wreg;
                exp_wd = p_wd; exp_wdata = p_data;
            end else begin
                exp_valid = 0; exp_wreg = 0;
            end
        end else if (id_valid_i) begin
            ref_op(aluop_i, alusel_i, reg1_i, reg2_i, ok, sh, r);
            if (sh && SERIAL) begin
                m_left = int'(reg1_i[4:0]) + 1;
                p_data = r; p_wd = wd_i; p_wreg = wreg_i;
                exp_valid = 0; exp_wreg = 0;
            end else begin
                exp_valid = 1;
                exp_wreg = wreg_i & ok;
                exp_wd = wd_i;
                exp_wdata = ok ? r : 32'h0;
            end
        end else begin
            exp_valid = 0; exp_wreg = 0;
        end
        exp_ready = (m_left == 0);
    endtask

    task automatic compare_all();
        check("ready", ex_ready_o, exp_ready);
        check("res_valid", res_valid_o, exp_valid);
        check("wreg", wreg_o, exp_wreg);
        check("wd", wd_o, exp_wd);
        check("wdata", wdata_o, exp_wdata);
        if (res_valid_o === 1'b1)
            got_q.push_back('{d: wdata_o, wd: wd_o, wreg: wreg_o});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_b(input logic v, input logic [7:0] op,
                         input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d,
                         input logic we);
        id_valid_i = v; aluop_i = op; alusel_i = sel;
        reg1_i = a; reg2_i = b; wd_i = d; wreg_i = we;
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic we);
        bit done = 0;
        set_b(1'b1, op, sel, a, b, d, we);
        for (int i = 0; i < 100 && !done; i++) begin
            done = exp_ready;
            cyc();
        end
        if (!done) begin
            miscompares++;
            $display("FAIL issue_timeout: got not-accepted expected accepted");
        end
        id_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && m_left != 0; i++) cyc();
        if (m_left != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got busy expected idle");
        end
    endtask

    task automatic expect_pop(input string name, input logic [31:0] d,
                              input logic [4:0] w, input logic we);
        res_t e;
        if (got_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no result expected %h", name, d);
        end else begin
            e = got_q.pop_front();
            check({name, "_data"}, e.d, d);
            check({name, "_wd"}, {27'd0, e.wd}, {27'd0, w});
            check({name, "_wreg"}, {31'd0, e.wreg}, {31'd0, we});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ops [8];
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_NOP};
        rst = 1'b1;
        flush_i = 1'b0;
        set_b(1'b1, OP_NOR, 3'd1, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);

        // Reset held two cycles with a valid bundle present
        cyc();
        cyc();
        check("rst_valid", res_valid_o, 1'b0);
        check("rst_wreg", wreg_o, 1'b0);
        check("rst_wd", wd_o, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_ready", ex_ready_o, 1'b1);
        got_q.delete();
        rst = 1'b0;

        // NOR, then wreg drops the cycle after
        issue(OP_NOR, 3'd1, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);
        expect_pop("nor", 32'hF000FF00, 5'd5, 1'b1);
        cyc();
        check("nor_wreg_drop", wreg_o, 1'b0);
        check("nor_wdata_hold", wdata_o, 32'hF000FF00);

        // Arithmetic shift right
        issue(OP_SRA, 3'd2, 32'd4, 32'h80000000, 5'd7, 1'b1);
        drain();
        expect_pop("sra", 32'hF8000000, 5'd7, 1'b1);

        // SLL then SRL back to back
        issue(OP_SLL, 3'd2, 32'd31, 32'h00000001, 5'd1, 1'b1);
        issue(OP_SRL, 3'd2, 32'd28, 32'hF0000000, 5'd2, 1'b1);
        drain();
        expect_pop("sll", 32'h80000000, 5'd1, 1'b1);
        expect_pop("srl", 32'h0000000F, 5'd2, 1'b1);

        // Flush during a long shift, then an OR completes normally
        issue(OP_SLL, 3'd2, 32'd20, 32'h00000001, 5'd3, 1'b1);
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("flush_valid", res_valid_o, 1'b0);
        check("flush_wreg", wreg_o, 1'b0);
        check("flush_ready", ex_ready_o, 1'b1);
`ifdef SERIAL_SHIFT_EN
        check("flush_dropped", got_q.size(), 32'd0);
`else
        expect_pop("flush_sll", 32'h00100000, 5'd3, 1'b1);
`endif
        issue(OP_OR, 3'd1, 32'h0000000F, 32'h000000F0, 5'd4, 1'b1);
        drain();
        expect_pop("or", 32'h000000FF, 5'd4, 1'b1);

        // Unknown class
        issue(OP_AND, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1);
        drain();
        expect_pop("unknown", 32'h0, 5'd9, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int pick;
            rst = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            if (exp_ready) begin
                pick = $urandom_range(0, 7);
                id_valid_i = ($urandom_range(0, 3) != 0);
                if (pick < 3) alusel_i = 3'd1;
                else if (pick < 6) alusel_i = 3'd2;
                else if (pick == 6) alusel_i = 3'd0;
                else alusel_i = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0)
                    aluop_i = 8'($urandom());
                else
                    aluop_i = ops[$urandom_range(0, 7)];
                reg1_i = $urandom();
                reg2_i = $urandom();
                wd_i = 5'($urandom());
                wreg_i = 1'($urandom());
            end
            cyc();
        end
        rst = 1'b0;
        flush_i = 1'b0;
        id_valid_i = 1'b0;
        drain();
        got_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
